pcpi_issuer: RTL and testbench

Initiator side of the PCPI coprocessor interface: accepts queued instruction commands (insn, rs1, rs2) from a host sequencer, drives them one at a time onto the PCPI bus of an attached coprocessor (e.g. the SRFPU), and returns each result or timeout on a valid/ready response port. It sits where the CPU core would, so a coprocessor can be exercised standalone, and it enforces the core's PCPI timeout rule.

---
 rtl/pcpi_issuer.sv | 206 ++++++++++++++++++++
 tb/tb_pcpi_issuer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_issuer.sv
// pcpi_issuer: PCPI initiator that stands in for the CPU core so a coprocessor can be run on its
// own. Commands (insn, rs1, rs2) are queued in a small FIFO and issued one at a time on the PCPI
// bus. Each completion, or each unclaimed instruction, is returned on a valid/ready response port.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command push handshake; cmd_insn/cmd_rs1/cmd_rs2 payload
//   pcpi_valid, pcpi_insn/rs1/rs2 registered instruction presented to the coprocessor
//   pcpi_wr, pcpi_rd             coprocessor write-enable and result
//   pcpi_wait, pcpi_ready        coprocessor claim/busy and done pulse
//   rsp_valid/rsp_ready          response handshake; rsp_data, rsp_wr, rsp_timeout payload
//   busy                         FIFO non-empty or an instruction/response in flight
//
// Build option: define PCPI_ISSUER_TIMEOUT_EN to enable the unclaimed-instruction timeout. When it
// is undefined, ISSUE waits for pcpi_ready indefinitely and rsp_timeout is tied low.
module pcpi_issuer #(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_insn,
    input  logic [31:0] cmd_rs1,
    input  logic [31:0] cmd_rs2,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_wr,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam int unsigned PtrW = $clog2(CMD_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e          state_q, state_d;
    logic [95:0]     mem_q [CMD_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full, empty, push, pop;

    logic            pcpi_valid_q, pcpi_valid_d;
    logic [31:0]     pcpi_insn_q, pcpi_insn_d, pcpi_rs1_q, pcpi_rs1_d, pcpi_rs2_q, pcpi_rs2_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_wr_q, rsp_wr_d;
    logic [31:0]     rsp_data_q, rsp_data_d;

`ifdef PCPI_ISSUER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            rsp_timeout_q, rsp_timeout_d;
`else
    logic unused_tmo;
    assign unused_tmo = pcpi_wait ^ (TIMEOUT_CYCLES == 0);
`endif

    // No bypass: a full FIFO refuses a push even if the FSM pops in the same cycle.
    assign full      = (count_q == CntW'(CMD_DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        pcpi_valid_d = pcpi_valid_q;
        pcpi_insn_d  = pcpi_insn_q;
        pcpi_rs1_d   = pcpi_rs1_q;
        pcpi_rs2_d   = pcpi_rs2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_wr_d     = rsp_wr_q;
`ifdef PCPI_ISSUER_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop = 1'b1;
                    {pcpi_insn_d, pcpi_rs1_d, pcpi_rs2_d} = mem_q[rd_ptr_q];
                    pcpi_valid_d = 1'b1;
`ifdef PCPI_ISSUER_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // A completion on the terminal timeout cycle still counts as a result.
                if (pcpi_ready) begin
                    pcpi_valid_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_wr_d     = pcpi_wr;
                    rsp_data_d   = pcpi_wr ? pcpi_rd : 32'h0;
`ifdef PCPI_ISSUER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    state_d = StResp;
                end
`ifdef PCPI_ISSUER_TIMEOUT_EN
                else if (pcpi_wait) begin
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TmoLast) begin
                    pcpi_valid_d  = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_wr_d      = 1'b0;
                    rsp_data_d    = 32'h0;
                    rsp_timeout_d = 1'b1;
                    state_d       = StResp;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
`endif
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Payload storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_insn, cmd_rs1, cmd_rs2};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pcpi_valid_q <= 1'b0;
            pcpi_insn_q  <= 32'h0;
            pcpi_rs1_q   <= 32'h0;
            pcpi_rs2_q   <= 32'h0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 32'h0;
            rsp_wr_q     <= 1'b0;
`ifdef PCPI_ISSUER_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pcpi_valid_q <= pcpi_valid_d;
            pcpi_insn_q  <= pcpi_insn_d;
            pcpi_rs1_q   <= pcpi_rs1_d;
            pcpi_rs2_q   <= pcpi_rs2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_wr_q     <= rsp_wr_d;
`ifdef PCPI_ISSUER_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign pcpi_valid = pcpi_valid_q;
    assign pcpi_insn  = pcpi_insn_q;
    assign pcpi_rs1   = pcpi_rs1_q;
    assign pcpi_rs2   = pcpi_rs2_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_wr     = rsp_wr_q;
`ifdef PCPI_ISSUER_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif
    assign busy = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_pcpi_issuer.sv
// Testbench for pcpi_issuer: a scripted coprocessor responder, a response monitor that checks
// against a queue of expected results, and directed plus randomized command streams.
module tb_pcpi_issuer;

    localparam int TC    = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_insn = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr = 1'b0;
    logic [31:0] pcpi_rd = '0;
    logic        pcpi_wait = 1'b0, pcpi_ready = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_wr, rsp_timeout, busy;

    pcpi_issuer #(.CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_insn(cmd_insn), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_wr(rsp_wr),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Responder script: pcpi_wait on valid cycles 1..wait_n, pcpi_ready on cycle ready_at
    // (0 = never).
    typedef struct {
        logic [31:0] insn, rs1, rs2, rd;
        logic        wr;
        int          wait_n;
        int          ready_at;
    } script_t;

    typedef struct {
        logic [31:0] data;
        logic        wr;
        logic        to;
        int          len;
    } exp_t;

    script_t script_q[$];
    exp_t    exp_q[$];
    int      errors = 0;
    int      checks = 0;
    logic    rsp_en = 1'b0;
    int      edge_cnt = 0;
    int      last_hs = -10;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Outcome from the rules: the result is taken if pcpi_ready comes no later than TC silent
    // cycles after the last pcpi_wait; otherwise the instruction times out at that point.
    function automatic exp_t model(input script_t s);
        exp_t e;
        logic to;
`ifdef PCPI_ISSUER_TIMEOUT_EN
        to = (s.ready_at == 0) || (s.ready_at > s.wait_n + TC);
        e.len = to ? s.wait_n + TC : s.ready_at;
`else
        to = 1'b0;
        e.len = s.ready_at;
`endif
        e.to   = to;
        e.wr   = !to && s.wr;
        e.data = (!to && s.wr) ? s.rd : 32'h0;
        return e;
    endfunction

    function automatic script_t mk(input logic [31:0] insn, rs1, rs2, input int wait_n,
                                   input int ready_at, input logic wr, input logic [31:0] rd);
        script_t s;
        s.insn = insn; s.rs1 = rs1; s.rs2 = rs2;
        s.wait_n = wait_n; s.ready_at = ready_at; s.wr = wr; s.rd = rd;
        return s;
    endfunction

    function automatic script_t rand_script();
        script_t s;
        int r;
        r = int'($urandom_range(0, 9));
        s.insn = $urandom; s.rs1 = $urandom; s.rs2 = $urandom; s.rd = $urandom;
        s.wr = 1'($urandom_range(0, 1));
        s.wait_n = (r == 9) ? int'($urandom_range(17, 30)) : int'($urandom_range(0, 4));
`ifdef PCPI_ISSUER_TIMEOUT_EN
        case (r)
            0:       s.ready_at = 0;
            1:       s.ready_at = s.wait_n + TC;
            2:       s.ready_at = s.wait_n + TC + 1;
            default: s.ready_at = s.wait_n + int'($urandom_range(1, TC - 1));
        endcase
`else
        s.ready_at = s.wait_n + int'($urandom_range(1, 20));
`endif
        return s;
    endfunction

    always @(posedge clk) edge_cnt++;

    // Coprocessor responder: follows the script while pcpi_valid is high, drives random noise on
    // the handshake inputs otherwise, and checks operands, issue spacing and valid duration.
    logic    active = 1'b0;
    int      cur_k = 0;
    script_t cur;
    exp_t    cur_e;

    always @(negedge clk) begin
        if (!resetn) begin
            active = 1'b0; cur_k = 0;
            pcpi_wait = 1'b0; pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0;
        end else if (pcpi_valid) begin
            if (!active) begin
                active = 1'b1;
                cur_k = 1;
                chk("issue_gap", 1'(edge_cnt >= last_hs + 2), 1'b1);
                if (script_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: actual=pcpi_valid required=idle");
                    cur = mk(32'h0, 32'h0, 32'h0, 0, 0, 1'b0, 32'h0);
                end else begin
                    cur = script_q.pop_front();
                end
                cur_e = model(cur);
                exp_q.push_back(cur_e);
            end else begin
                cur_k++;
            end
            chk("pcpi_operands", {pcpi_insn, pcpi_rs1, pcpi_rs2}, {cur.insn, cur.rs1, cur.rs2});
            pcpi_ready = (cur_k == cur.ready_at);
            pcpi_wait  = (cur_k <= cur.wait_n) && !pcpi_ready;
            pcpi_wr    = pcpi_ready ? cur.wr : 1'($urandom_range(0, 1));
            pcpi_rd    = pcpi_ready ? cur.rd : $urandom;
        end else begin
            if (active) begin
                chk("valid_cycles", cur_k, cur_e.len);
                active = 1'b0;
            end
            pcpi_wait  = 1'($urandom_range(0, 1));
            pcpi_ready = 1'($urandom_range(0, 1));
            pcpi_wr    = 1'($urandom_range(0, 1));
            pcpi_rd    = $urandom;
        end
    end

    // Response monitor: pops the scoreboard on every handshake and checks held responses.
    logic        hold = 1'b0;
    logic [33:0] held = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            rsp_ready = 1'b0;
            hold = 1'b0;
        end else begin
            if (hold)
                chk("rsp_stable", {rsp_valid, rsp_data, rsp_wr, rsp_timeout}, {1'b1, held});
            rsp_ready = rsp_en ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rsp_valid && rsp_ready) begin
                last_hs = edge_cnt;
                hold = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: actual=%0h required=none", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp", {rsp_data, rsp_wr, rsp_timeout}, {e.data, e.wr, e.to});
                end
            end else begin
                hold = rsp_valid;
                held = {rsp_data, rsp_wr, rsp_timeout};
            end
        end
    end

    // Called at a negedge; leaves cmd_valid high so consecutive calls are back-to-back.
    task automatic push(input script_t s);
        int g = 0;
        while (!cmd_ready && g < 1000) begin
            cmd_valid = 1'b0;
            @(negedge clk);
            g++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_ready_wait: actual=0 required=1");
        end else begin
            cmd_valid = 1'b1;
            cmd_insn = s.insn; cmd_rs1 = s.rs1; cmd_rs2 = s.rs2;
            script_q.push_back(s);
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int g = 0;
        cmd_valid = 1'b0;
        while (g < 3000 && (script_q.size() != 0 || exp_q.size() != 0 || busy || pcpi_valid
                            || rsp_valid)) begin
            @(negedge clk);
            g++;
        end
        chk("drain", 1'(g < 3000), 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0;
        cmd_valid = 1'b0;
        script_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", {pcpi_valid, rsp_valid, rsp_wr, rsp_timeout, busy, cmd_ready}, 6'b000001);
        chk("rst_pcpi_ops", {pcpi_insn, pcpi_rs1, pcpi_rs2}, 96'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
    endtask

    initial begin
        script_t s;
        do_reset();
        rsp_en = 1'b1;

        push(mk(32'h0020F0D3, 32'h3F800000, 32'h40000000, 3, 4, 1'b1, 32'h40400000));
        drain();
`ifdef PCPI_ISSUER_TIMEOUT_EN
        push(mk($urandom, $urandom, $urandom, 0, 0, 1'b1, 32'h12345678));
        drain();
        push(mk($urandom, $urandom, $urandom, 0, TC, 1'b1, 32'hCAFE0001));
        drain();
        push(mk($urandom, $urandom, $urandom, 2, 2 + TC, 1'b1, 32'hCAFE0002));
        drain();
        push(mk($urandom, $urandom, $urandom, 0, TC + 1, 1'b1, 32'hCAFE0003));
        drain();
`endif
        push(mk($urandom, $urandom, $urandom, 40, 41, 1'b0, 32'hDEADBEEF));
        drain();

        // Backpressure: park the FSM in RESP, then fill the FIFO.
        rsp_en = 1'b0;
        @(negedge clk);
        push(mk($urandom, $urandom, $urandom, 0, 1, 1'b1, $urandom));
        cmd_valid = 1'b0;
        for (int g = 0; g < 50 && !rsp_valid; g++) @(negedge clk);
        chk("bp_rsp_parked", rsp_valid, 1'b1);
        for (int i = 0; i < DEPTH; i++) push(rand_script());
        chk("bp_full", {cmd_ready, busy}, 2'b01);
        rsp_en = 1'b1;
        push(rand_script());
        drain();

        for (int i = 0; i < 40; i++) begin
            push(rand_script());
            if ($urandom_range(0, 3) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 20)) @(negedge clk);
            end
        end
        drain();

        // Reset with one instruction held in ISSUE and three queued.
`ifdef PCPI_ISSUER_TIMEOUT_EN
        s = mk($urandom, $urandom, $urandom, 100000, 0, 1'b1, $urandom);
`else
        s = mk($urandom, $urandom, $urandom, 0, 0, 1'b1, $urandom);
`endif
        push(s);
        for (int i = 0; i < 3; i++) push(rand_script());
        cmd_valid = 1'b0;
        repeat (110) @(negedge clk);
        chk("long_issue", {pcpi_valid, busy, 1'(cur_k >= 100)}, 3'b111);
        do_reset();
        repeat (40) @(negedge clk);
        chk("post_reset_idle", {pcpi_valid, rsp_valid, busy}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        checks++;
        errors++;
        $display("FAIL watchdog: actual=running required=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
